paddle_cmd_sched: RTL and testbench
===================================

Name: paddle_cmd_sched

Overview:
Controller that turns player commands into paddle motion for the Pong core. It takes decoded UART bytes and on-board buttons and arbitrates between them per paddle. It schedules paddle steps on a fixed-rate tick, clamps both paddle Y positions to the playfield, and runs a small run/pause/recentre state machine. It sits between the UART receive path and the renderer/collision logic.

Parameters:
HOLD_CYCLES, 10000, cycles a UART key stays active after its byte is received (retriggerable)
STEP_CYCLES, 250000, cycles between motion ticks
Y_WIDTH, 10, width of paddle Y positions
Y_MIN, 0, top clamp (inclusive)
Y_MAX, 400, bottom clamp (inclusive)
Y_INIT, 200, reset/recentre position
STEP_PX, 2, pixels moved per tick

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rx_data  in  8  received UART byte
rx_valid  in  1  one-cycle strobe; rx_data is valid
btn  in  4  synchronised button levels, same bit map as move
move  out  4  arbitrated active direction: [0]=right up (I), [1]=right down (K), [2]=left up (W), [3]=left down (S)
left_y  out  Y_WIDTH  left paddle top Y
right_y  out  Y_WIDTH  right paddle top Y
paused  out  1  high in PAUSE

Behaviour:
- Reset (async, rst_n=0): state RUN; left_y=right_y=Y_INIT; move=0; paused=0; hold counters and step timer=0.
- Byte decode on rx_valid, case-insensitive:
  - I/i, K/k, W/w, S/s: load that key's hold counter with HOLD_CYCLES. Reloading while the counter is nonzero restarts it. Other keys' counters are unchanged.
  - P/p: toggle RUN<->PAUSE.
  - R/r: go to CENTER.
  - Any other byte: ignored.
- Hold counter: decrements by 1 per cycle while nonzero. uart_key[k] = (counter != 0).
- Source arbitration, per paddle: if either btn bit for that paddle is 1, that paddle uses its btn pair; otherwise it uses its uart_key pair. Sources are never mixed within one paddle.
- Conflict: if up and down are both active for a paddle after arbitration, neither is active.
- move: registered arbitration result; forced 0 in PAUSE and CENTER. Latency: rx_valid at edge N, counter nonzero after N, move asserted after edge N+1.
- Step timer:
  - RUN: counts 0..STEP_CYCLES-1 and wraps; tick is high for one cycle at STEP_CYCLES-1.
  - PAUSE/CENTER: timer held at 0.
- On tick in RUN, each paddle:
  - Up: y = max(y - STEP_PX, Y_MIN).
  - Down: y = min(y + STEP_PX, Y_MAX).
  - Arithmetic is done in Y_WIDTH+1 bits signed, so there is no wrap at 0 or at the top.
  - The tick uses the registered move, so a byte arriving in the tick cycle affects the next tick only.
- FSM:
  - RUN: P -> PAUSE; R -> CENTER.
  - PAUSE: P -> RUN; R -> CENTER. Hold counters keep running but move=0.
  - CENTER (one cycle): both y=Y_INIT, all hold counters cleared, timer cleared -> RUN.
  - P and R are mutually exclusive by construction (one byte per strobe).
- While the FSM is in CENTER, an rx_valid key byte is ignored and a P byte is ignored.
- Positions never leave [Y_MIN, Y_MAX], including immediately after reset or CENTER.

Decomposition:
- Shared package pong_pkg:
  - ASCII constants for I, K, W, S, P, R (both cases).
  - move bit indices (MV_R_UP=0, MV_R_DN=1, MV_L_UP=2, MV_L_DN=3).
  - State enum {RUN, PAUSE, CENTER}.
- One sub-module key_hold_timer (load, count-down, active output), instantiated 4x.
- Arbitration, step timer, clamp and FSM stay in the top.

Test Plan:
(bench params HOLD_CYCLES=20, STEP_CYCLES=4, Y_MIN=0, Y_MAX=20, Y_INIT=10, STEP_PX=2)
- rx 'w', no buttons -> move=4'b0100 two cycles later. left_y 10->8->6->... on each tick, for 20 cycles of hold (5 ticks, left_y=0). Move then drops to 0, and left_y stays at 0 (clamped; 6th tick would not underflow).
- rx 'K' then hold btn[0]=1 -> right paddle follows the button (up) and ignores UART down. Release btn -> right moves down for the remaining UART hold time.
- rx 'i' and 'k' in consecutive cycles -> move[1:0]=00, right_y unchanged at 10 across 3 ticks.
- rx 's' repeatedly every 10 cycles for 80 cycles -> left_y rises to 20 and stays; move[3] never drops between retriggers.
- rx 'p' -> paused=1, move=0, positions frozen even with btn=4'b1111. rx 'P' -> resumes; first tick 4 cycles later.
- Move paddles off-centre, rx 'r' -> one cycle later left_y=right_y=10, move=0, state RUN. Assert rst_n=0 mid-hold -> all outputs at reset values immediately (asynchronous).

Source files
------------

// File: rtl/pong_pkg.sv
// Shared definitions for the Pong command path: command byte codes, move bit map,
// scheduler states and the UART byte decoder.
package pong_pkg;

    // ASCII codes of the command bytes, both cases
    localparam logic [7:0] ASCII_I_UC = 8'h49;
    localparam logic [7:0] ASCII_I_LC = 8'h69;
    localparam logic [7:0] ASCII_K_UC = 8'h4B;
    localparam logic [7:0] ASCII_K_LC = 8'h6B;
    localparam logic [7:0] ASCII_W_UC = 8'h57;
    localparam logic [7:0] ASCII_W_LC = 8'h77;
    localparam logic [7:0] ASCII_S_UC = 8'h53;
    localparam logic [7:0] ASCII_S_LC = 8'h73;
    localparam logic [7:0] ASCII_P_UC = 8'h50;
    localparam logic [7:0] ASCII_P_LC = 8'h70;
    localparam logic [7:0] ASCII_R_UC = 8'h52;
    localparam logic [7:0] ASCII_R_LC = 8'h72;

    // Bit positions inside move / btn / key vectors
    localparam int unsigned MV_R_UP = 0;
    localparam int unsigned MV_R_DN = 1;
    localparam int unsigned MV_L_UP = 2;
    localparam int unsigned MV_L_DN = 3;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        PAUSE  = 2'd1,
        CENTER = 2'd2
    } sched_state_e;

    // One decoded UART byte: at most one field is set
    typedef struct packed {
        logic [3:0] key_load;
        logic       toggle_pause;
        logic       recentre;
    } rx_cmd_t;

    // Map one received byte to a command; unknown bytes decode to nothing
    function automatic rx_cmd_t decode_rx(input logic [7:0] rx_byte);
        rx_cmd_t cmd;
        cmd = '0;
        case (rx_byte)
            ASCII_I_UC, ASCII_I_LC: cmd.key_load[MV_R_UP] = 1'b1;
            ASCII_K_UC, ASCII_K_LC: cmd.key_load[MV_R_DN] = 1'b1;
            ASCII_W_UC, ASCII_W_LC: cmd.key_load[MV_L_UP] = 1'b1;
            ASCII_S_UC, ASCII_S_LC: cmd.key_load[MV_L_DN] = 1'b1;
            ASCII_P_UC, ASCII_P_LC: cmd.toggle_pause      = 1'b1;
            ASCII_R_UC, ASCII_R_LC: cmd.recentre          = 1'b1;
            default:                cmd                   = '0;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/key_hold_timer.sv
// Retriggerable hold timer for one UART direction key. A load restarts the count at
// HOLD_CYCLES; the key reads as active while the count is nonzero.
module key_hold_timer #(
    parameter int unsigned HOLD_CYCLES = 10000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic clear_i,
    output logic active_o
);

    localparam int unsigned CntW = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
    localparam logic [CntW-1:0] HoldLoad = CntW'(HOLD_CYCLES);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Next count: clear beats load, load beats the count-down
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = HoldLoad;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign active_o = (cnt_q != '0);

endmodule

// File: rtl/paddle_cmd_sched.sv
// Paddle command scheduler: decodes UART command bytes, arbitrates them against the
// on-board buttons per paddle, steps both paddles on a fixed-rate tick with clamping,
// and runs the RUN / PAUSE / CENTER control state machine.
module paddle_cmd_sched
    import pong_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 10000,
    parameter int unsigned STEP_CYCLES = 250000,
    parameter int unsigned Y_WIDTH     = 10,
    parameter int unsigned Y_MIN       = 0,
    parameter int unsigned Y_MAX       = 400,
    parameter int unsigned Y_INIT      = 200,
    parameter int unsigned STEP_PX     = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    input  logic [3:0]         btn,
    output logic [3:0]         move,
    output logic [Y_WIDTH-1:0] left_y,
    output logic [Y_WIDTH-1:0] right_y,
    output logic               paused
);

    // Step timer sizing
    localparam int unsigned TmrW = (STEP_CYCLES < 2) ? 1 : $clog2(STEP_CYCLES);
    localparam logic [TmrW-1:0] StepLast = TmrW'(STEP_CYCLES - 1);

    // Start/recentre position, pulled inside the playfield in case Y_INIT lies outside
    localparam int unsigned YInitC = (Y_INIT < Y_MIN) ? Y_MIN :
                                     ((Y_INIT > Y_MAX) ? Y_MAX : Y_INIT);
    localparam logic [Y_WIDTH-1:0] YInitV = Y_WIDTH'(YInitC);

    // Position arithmetic is one bit wider and signed so neither end can wrap
    localparam logic signed [Y_WIDTH:0] YMinS  = (Y_WIDTH + 1)'(Y_MIN);
    localparam logic signed [Y_WIDTH:0] YMaxS  = (Y_WIDTH + 1)'(Y_MAX);
    localparam logic signed [Y_WIDTH:0] StepS  = (Y_WIDTH + 1)'(STEP_PX);

    sched_state_e        state_q, state_d;
    rx_cmd_t             cmd;
    logic [3:0]          key_load;
    logic                key_clear;
    logic [3:0]          uart_key;
    logic [1:0]          r_sel, l_sel;
    logic [3:0]          move_q, move_d;
    logic [TmrW-1:0]     timer_q, timer_d;
    logic                step_tick;
    logic [Y_WIDTH-1:0]  left_y_q, left_y_d;
    logic [Y_WIDTH-1:0]  right_y_q, right_y_d;

    // One clamped step of a paddle; up has priority only nominally, conflicts are
    // already removed by the arbiter
    function automatic logic [Y_WIDTH-1:0] step_pos(input logic [Y_WIDTH-1:0] y,
                                                    input logic up,
                                                    input logic dn);
        logic signed [Y_WIDTH:0] ys;
        logic signed [Y_WIDTH:0] nxt;
        ys  = $signed({1'b0, y});
        nxt = ys;
        if (up) begin
            nxt = ys - StepS;
            if (nxt < YMinS) begin
                nxt = YMinS;
            end
        end else if (dn) begin
            nxt = ys + StepS;
            if (nxt > YMaxS) begin
                nxt = YMaxS;
            end
        end
        return nxt[Y_WIDTH-1:0];
    endfunction

    // Decode the strobed byte; key bytes are dropped while recentring
    always_comb begin
        cmd       = rx_valid ? decode_rx(rx_data) : '0;
        key_clear = (state_q == CENTER);
        key_load  = key_clear ? 4'b0000 : cmd.key_load;
    end

    for (genvar k = 0; k < 4; k++) begin : g_hold
        key_hold_timer #(
            .HOLD_CYCLES (HOLD_CYCLES)
        ) u_key_hold_timer (
            .clk      (clk),
            .rst_n    (rst_n),
            .load_i   (key_load[k]),
            .clear_i  (key_clear),
            .active_o (uart_key[k])
        );
    end

    // Per-paddle source select (any button wins the whole paddle), then conflict cancel
    always_comb begin
        r_sel = (btn[MV_R_DN:MV_R_UP] != 2'b00) ? btn[MV_R_DN:MV_R_UP]
                                                : uart_key[MV_R_DN:MV_R_UP];
        l_sel = (btn[MV_L_DN:MV_L_UP] != 2'b00) ? btn[MV_L_DN:MV_L_UP]
                                                : uart_key[MV_L_DN:MV_L_UP];
        if (r_sel == 2'b11) begin
            r_sel = 2'b00;
        end
        if (l_sel == 2'b11) begin
            l_sel = 2'b00;
        end
        // Nothing carries out of CENTER, so move is clean on the first RUN cycle
        move_d = (state_q == CENTER) ? 4'b0000 : {l_sel, r_sel};
    end

    // Motion tick: timer only runs while staying in RUN
    always_comb begin
        step_tick = (state_q == RUN) && (timer_q == StepLast);
        timer_d   = '0;
        if ((state_q == RUN) && (state_d == RUN)) begin
            timer_d = step_tick ? '0 : timer_q + TmrW'(1);
        end
    end

    // Paddle positions: recentre in CENTER, otherwise step on tick from the registered move
    always_comb begin
        left_y_d  = left_y_q;
        right_y_d = right_y_q;
        if (state_q == CENTER) begin
            left_y_d  = YInitV;
            right_y_d = YInitV;
        end else if (step_tick) begin
            left_y_d  = step_pos(left_y_q, move_q[MV_L_UP], move_q[MV_L_DN]);
            right_y_d = step_pos(right_y_q, move_q[MV_R_UP], move_q[MV_R_DN]);
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; P and R never arrive together since one byte comes per strobe
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (cmd.toggle_pause) begin
                    state_d = PAUSE;
                end else if (cmd.recentre) begin
                    state_d = CENTER;
                end
            end
            PAUSE: begin
                if (cmd.toggle_pause) begin
                    state_d = RUN;
                end else if (cmd.recentre) begin
                    state_d = CENTER;
                end
            end
            CENTER:  state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // FSM outputs: move is only visible while running
    always_comb begin
        paused = (state_q == PAUSE);
        move   = (state_q == RUN) ? move_q : 4'b0000;
    end

    // Datapath registers: registered move, step timer, paddle positions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            move_q    <= 4'b0000;
            timer_q   <= '0;
            left_y_q  <= YInitV;
            right_y_q <= YInitV;
        end else begin
            move_q    <= move_d;
            timer_q   <= timer_d;
            left_y_q  <= left_y_d;
            right_y_q <= right_y_d;
        end
    end

    assign left_y  = left_y_q;
    assign right_y = right_y_q;

endmodule

// File: tb/tb_paddle_cmd_sched.sv
// Self-checking bench for paddle_cmd_sched. A behavioural model advances on every
// clock edge and pushes the expected outputs; they are popped and compared half a
// cycle later. Directed checks cover the scenario-specific values.
module tb_paddle_cmd_sched;

    localparam int HOLD  = 20;
    localparam int STEP  = 4;
    localparam int YW    = 10;
    localparam int YMIN  = 0;
    localparam int YMAX  = 20;
    localparam int YINIT = 10;
    localparam int SPX   = 2;

    localparam int ST_RUN    = 0;
    localparam int ST_PAUSE  = 1;
    localparam int ST_CENTER = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic [3:0]    btn = 4'b0000;
    logic [3:0]    move;
    logic [YW-1:0] left_y;
    logic [YW-1:0] right_y;
    logic          paused;

    always #5 clk = ~clk;

    paddle_cmd_sched #(
        .HOLD_CYCLES (HOLD),
        .STEP_CYCLES (STEP),
        .Y_WIDTH     (YW),
        .Y_MIN       (YMIN),
        .Y_MAX       (YMAX),
        .Y_INIT      (YINIT),
        .STEP_PX     (SPX)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .btn      (btn),
        .move     (move),
        .left_y   (left_y),
        .right_y  (right_y),
        .paused   (paused)
    );

    typedef struct packed {
        logic [3:0]    mv;
        logic [YW-1:0] ly;
        logic [YW-1:0] ry;
        logic          ps;
    } obs_t;

    obs_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;

    // Reference model state
    int         m_hold[4];
    int         m_timer;
    int         m_st;
    int         m_ly;
    int         m_ry;
    logic [3:0] m_mv;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d required %0d (cycle %0d)", tag, obs, exp, cycle);
        end
    endtask

    function automatic logic [7:0] to_upper(input logic [7:0] b);
        return (b >= 8'h61 && b <= 8'h7A) ? b - 8'h20 : b;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) m_hold[k] = 0;
        m_timer = 0;
        m_st    = ST_RUN;
        m_ly    = YINIT;
        m_ry    = YINIT;
        m_mv    = 4'b0000;
    endtask

    task automatic model_clock();
        int         st0;
        int         nst;
        bit         tick;
        bit         tp;
        bit         rc;
        logic [7:0] u;
        logic [3:0] ld;
        logic [1:0] r;
        logic [1:0] l;
        st0  = m_st;
        tick = (st0 == ST_RUN) && (m_timer == STEP - 1);
        u    = to_upper(rx_data);
        ld   = 4'b0000;
        tp   = 1'b0;
        rc   = 1'b0;
        if (rx_valid) begin
            case (u)
                8'h49: if (st0 != ST_CENTER) ld[0] = 1'b1; // I
                8'h4B: if (st0 != ST_CENTER) ld[1] = 1'b1; // K
                8'h57: if (st0 != ST_CENTER) ld[2] = 1'b1; // W
                8'h53: if (st0 != ST_CENTER) ld[3] = 1'b1; // S
                8'h50: tp = 1'b1;                          // P
                8'h52: rc = 1'b1;                          // R
                default: ;
            endcase
        end
        r = (btn[1:0] != 2'b00) ? btn[1:0] : {m_hold[1] != 0, m_hold[0] != 0};
        l = (btn[3:2] != 2'b00) ? btn[3:2] : {m_hold[3] != 0, m_hold[2] != 0};
        if (r == 2'b11) r = 2'b00;
        if (l == 2'b11) l = 2'b00;
        if (st0 == ST_CENTER) begin
            m_ly = YINIT;
            m_ry = YINIT;
        end else if (tick) begin
            if (m_mv[0]) m_ry = (m_ry - SPX < YMIN) ? YMIN : m_ry - SPX;
            if (m_mv[1]) m_ry = (m_ry + SPX > YMAX) ? YMAX : m_ry + SPX;
            if (m_mv[2]) m_ly = (m_ly - SPX < YMIN) ? YMIN : m_ly - SPX;
            if (m_mv[3]) m_ly = (m_ly + SPX > YMAX) ? YMAX : m_ly + SPX;
        end
        m_mv = (st0 == ST_CENTER) ? 4'b0000 : {l, r};
        for (int k = 0; k < 4; k++) begin
            if (st0 == ST_CENTER)  m_hold[k] = 0;
            else if (ld[k])        m_hold[k] = HOLD;
            else if (m_hold[k] > 0) m_hold[k] = m_hold[k] - 1;
        end
        case (st0)
            ST_RUN:   nst = tp ? ST_PAUSE : (rc ? ST_CENTER : ST_RUN);
            ST_PAUSE: nst = tp ? ST_RUN : (rc ? ST_CENTER : ST_PAUSE);
            default:  nst = ST_RUN;
        endcase
        m_timer = (st0 == ST_RUN && nst == ST_RUN) ? (tick ? 0 : m_timer + 1) : 0;
        m_st    = nst;
    endtask

    // One clock: model advances on the rising edge, DUT is compared on the falling edge
    task automatic step();
        obs_t exp;
        obs_t got;
        @(posedge clk);
        cycle++;
        if (!rst_n) model_reset();
        else        model_clock();
        exp.mv = (m_st == ST_RUN) ? m_mv : 4'b0000;
        exp.ly = YW'(m_ly);
        exp.ry = YW'(m_ry);
        exp.ps = (m_st == ST_PAUSE);
        sb_q.push_back(exp);
        @(negedge clk);
        got = {move, left_y, right_y, paused};
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            exp = sb_q.pop_front();
            checks++;
            assert (got === exp) else begin
                errors++;
                $error("FAIL scoreboard: observed mv=%b ly=%0d ry=%0d ps=%b required mv=%b ly=%0d ry=%0d ps=%b (cycle %0d)",
                       got.mv, got.ly, got.ry, got.ps, exp.mv, exp.ly, exp.ry, exp.ps, cycle);
            end
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end (cycle %0d)", cycle);
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        steps(2);
        check("reset_move", 32'(move), 32'd0);
        check("reset_left_y", 32'(left_y), 32'(YINIT));
        check("reset_right_y", 32'(right_y), 32'(YINIT));
        check("reset_paused", 32'(paused), 32'd0);
        rst_n = 1'b1;
        steps(1);

        // 'w' alone: left up after two edges, five ticks bring it down to the clamp
        send(8'h77);
        check("w_latency_move", 32'(move), 32'd0);
        step();
        check("w_move", 32'(move), 32'b0100);
        steps(25);
        check("w_left_clamped", 32'(left_y), 32'd0);
        check("w_move_released", 32'(move), 32'd0);

        // 'K' then button up: button owns the right paddle, then the UART hold resumes
        send(8'h4B);
        btn = 4'b0001;
        steps(8);
        check("btn_overrides_uart", 32'(move), 32'b0001);
        btn = 4'b0000;
        step();
        check("uart_after_release", 32'(move), 32'b0010);
        steps(20);
        check("k_hold_expired", 32'(move), 32'd0);

        // Recentre from off-centre positions
        send(8'h72);
        check("center_move", 32'(move), 32'd0);
        step();
        check("center_left_y", 32'(left_y), 32'(YINIT));
        check("center_right_y", 32'(right_y), 32'(YINIT));
        check("center_move_after", 32'(move), 32'd0);
        check("center_to_run", 32'(paused), 32'd0);

        // 'i' and 'k' back to back cancel each other
        send(8'h69);
        send(8'h6B);
        steps(12);
        check("ik_conflict_move", 32'(move[1:0]), 32'd0);
        check("ik_right_y_mid", 32'(right_y), 32'(YINIT));
        steps(12);
        check("ik_right_y_end", 32'(right_y), 32'(YINIT));

        // 's' retriggered every 10 cycles keeps move[3] high and pins left at Y_MAX
        for (int it = 0; it < 8; it++) begin
            send(8'h73);
            for (int j = 0; j < 9; j++) begin
                step();
                check("s_retrigger_move3", 32'(move[3]), 32'd1);
            end
        end
        check("s_left_at_max", 32'(left_y), 32'(YMAX));
        steps(25);
        check("s_move_released", 32'(move), 32'd0);
        check("s_left_stays_max", 32'(left_y), 32'(YMAX));

        // Pause freezes everything even with buttons held
        send(8'h70);
        check("pause_flag", 32'(paused), 32'd1);
        check("pause_move", 32'(move), 32'd0);
        btn = 4'b0101;
        steps(10);
        check("pause_move_btn", 32'(move), 32'd0);
        check("pause_left_frozen", 32'(left_y), 32'(YMAX));
        check("pause_right_frozen", 32'(right_y), 32'(YINIT));
        btn = 4'b0001;
        send(8'h50);
        check("resume_flag", 32'(paused), 32'd0);
        steps(3);
        check("resume_before_tick", 32'(right_y), 32'(YINIT));
        step();
        check("resume_first_tick", 32'(right_y), 32'(YINIT - SPX));
        btn = 4'b0000;

        // Asynchronous reset in the middle of a hold
        send(8'h57);
        steps(10);
        rst_n = 1'b0;
        #1;
        check("async_rst_move", 32'(move), 32'd0);
        check("async_rst_left_y", 32'(left_y), 32'(YINIT));
        check("async_rst_right_y", 32'(right_y), 32'(YINIT));
        check("async_rst_paused", 32'(paused), 32'd0);
        model_reset();
        steps(2);
        rst_n = 1'b1;
        steps(5);
        check("post_reset_move", 32'(move), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
